pwm_frame_gen: RTL and testbench



---
 rtl/pwm_frame_if.sv | 24 ++
 rtl/pwm_frame_gen.sv | 113 +++++++++++
 tb/tb_pwm_frame_gen.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_frame_if.sv
// Handshake-free control/status bundle for the PWM frame generator.
// master drives the run request and codes, slave returns the waveform.
interface pwm_frame_if #(
    parameter int W   = 16,
    parameter int FCW = 16
);
    logic           enable;
    logic [W-1:0]   duty_i;
    logic [W-1:0]   period_i;
    logic           pwm_o;
    logic           sample_o;
    logic           busy_o;
    logic [FCW-1:0] frame_cnt_o;

    modport master (
        output enable, duty_i, period_i,
        input  pwm_o, sample_o, busy_o, frame_cnt_o
    );

    modport slave (
        input  enable, duty_i, period_i,
        output pwm_o, sample_o, busy_o, frame_cnt_o
    );
endinterface

// File: rtl/pwm_frame_gen.sv
// Double-buffered PWM frame generator with end-of-frame strobe
// and an IDLE/RUN/STOP state machine for graceful draining.
module pwm_frame_gen #(
    parameter int W   = 16,
    parameter int FCW = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    pwm_frame_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t         state, state_d;
    logic [W-1:0]   cnt, cnt_d;
    logic [W-1:0]   duty_q, duty_d;
    logic [W-1:0]   period_q, period_d;
    logic           pwm_q, pwm_d;
    logic           sample_q, sample_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;

    logic [W-1:0]   p_ld, d_ld;
    logic [W-1:0]   cnt_inc, last_idx;
    logic           last;

    // Load rule: zero period means one cycle, duty clamps at 100%
    always_comb begin
        p_ld = (bus.period_i == '0) ? W'(1) : bus.period_i;
        d_ld = (bus.duty_i > p_ld) ? p_ld : bus.duty_i;
    end

    assign cnt_inc  = cnt + W'(1);
    assign last_idx = period_q - W'(1);
    assign last     = (cnt == last_idx);

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        duty_d   = duty_q;
        period_d = period_q;
        pwm_d    = pwm_q;
        sample_d = 1'b0;
        fcnt_d   = fcnt_q;
        unique case (state)
            IDLE: begin
                cnt_d = '0;
                pwm_d = 1'b0;
                if (bus.enable) begin
                    state_d  = RUN;
                    duty_d   = d_ld;
                    period_d = p_ld;
                    pwm_d    = (d_ld != '0);
                    sample_d = (p_ld == W'(1));
                end
            end
            RUN, STOP: begin
                if (last) begin
                    fcnt_d = fcnt_q + FCW'(1);
                    cnt_d  = '0;
                    // A draining frame ends in IDLE unless re-enabled right here
                    if (state == RUN || bus.enable) begin
                        state_d  = bus.enable ? RUN : STOP;
                        duty_d   = d_ld;
                        period_d = p_ld;
                        pwm_d    = (d_ld != '0);
                        sample_d = bus.enable && (p_ld == W'(1));
                    end else begin
                        state_d = IDLE;
                        pwm_d   = 1'b0;
                    end
                end else begin
                    state_d  = bus.enable ? RUN : STOP;
                    cnt_d    = cnt_inc;
                    pwm_d    = (cnt_inc < duty_q);
                    sample_d = bus.enable && (cnt_inc == last_idx);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                pwm_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            duty_q   <= '0;
            period_q <= '0;
            pwm_q    <= 1'b0;
            sample_q <= 1'b0;
            fcnt_q   <= '0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            duty_q   <= duty_d;
            period_q <= period_d;
            pwm_q    <= pwm_d;
            sample_q <= sample_d;
            fcnt_q   <= fcnt_d;
        end
    end

    assign bus.pwm_o       = pwm_q;
    assign bus.sample_o    = sample_q;
    assign bus.busy_o      = (state != IDLE);
    assign bus.frame_cnt_o = fcnt_q;
endmodule

// File: tb/tb_pwm_frame_gen.sv
// Scoreboard bench for pwm_frame_gen: frame-level reference model
// feeds an expectation queue drained by a negedge monitor.
module tb_pwm_frame_gen;
    localparam int W   = 16;
    localparam int FCW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pwm_frame_if #(.W(W), .FCW(FCW)) bus ();

    pwm_frame_gen #(.W(W), .FCW(FCW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic           pwm;
        logic           sample;
        logic           busy;
        logic [FCW-1:0] fc;
    } exp_t;

    exp_t q[$];
    int   vecs = 0;
    int   errs = 0;

    // Reference: position k inside a frame of P cycles with D high
    bit m_act, m_stop, m_en;
    int m_k, m_p, m_d, m_fc;

    task automatic m_load();
        m_p = (bus.period_i == 0) ? 1 : int'(bus.period_i);
        m_d = (int'(bus.duty_i) > m_p) ? m_p : int'(bus.duty_i);
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            m_act = 0; m_stop = 0; m_en = 0;
            m_k = 0; m_p = 0; m_d = 0; m_fc = 0;
        end else begin
            m_en = bus.enable;
            if (!m_act) begin
                if (bus.enable) begin
                    m_act = 1; m_stop = 0; m_k = 0;
                    m_load();
                end
            end else if (m_k == m_p - 1) begin
                m_fc = (m_fc + 1) % (1 << FCW);
                m_k  = 0;
                if (bus.enable || !m_stop) begin
                    m_load();
                    m_stop = !bus.enable;
                end else begin
                    m_act = 0;
                end
            end else begin
                m_k++;
                m_stop = !bus.enable;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.pwm    = m_act && (m_k < m_d);
        e.sample = m_act && m_en && (m_k == m_p - 1);
        e.busy   = m_act;
        e.fc     = FCW'(m_fc);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        q.push_back(model_out());
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string name, input int act, input int req);
        vecs++;
        if (act != req) begin
            errs++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, req, $time);
        end
    endtask

    // Advance until the model sits at frame position k (bounded)
    task automatic wait_k(input int k);
        int n = 0;
        while (!(m_act && m_k == k) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("wait_k_timeout", n, 0);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            vecs++;
            if (bus.pwm_o !== e.pwm || bus.sample_o !== e.sample ||
                bus.busy_o !== e.busy || bus.frame_cnt_o !== e.fc) begin
                errs++;
                $display("FAIL cycle t=%0t: pwm/sample/busy/fc got %b/%b/%b/%0d want %b/%b/%b/%0d",
                         $time, bus.pwm_o, bus.sample_o, bus.busy_o, bus.frame_cnt_o,
                         e.pwm, e.sample, e.busy, e.fc);
            end
        end
    end

    task automatic async_reset();
        rst_n = 1'b0;
        q.delete();
        #1;
        check("rst_pwm", int'(bus.pwm_o), 0);
        check("rst_sample", int'(bus.sample_o), 0);
        check("rst_busy", int'(bus.busy_o), 0);
        check("rst_fc", int'(bus.frame_cnt_o), 0);
        model_edge();
        run(2);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.enable   = 1'b0;
        bus.duty_i   = '0;
        bus.period_i = '0;
        run(3);
        rst_n = 1'b1;
        run(2);

        bus.period_i = 16'd10;
        bus.duty_i   = 16'd3;
        bus.enable   = 1'b1;
        run(35);

        wait_k(4);
        bus.duty_i = 16'd7;
        run(25);

        bus.duty_i = 16'd0;
        run(22);
        bus.duty_i = 16'd10;
        run(22);
        bus.duty_i = 16'd500;
        run(22);

        bus.period_i = 16'd0;
        bus.duty_i   = 16'd1;
        run(12);
        bus.duty_i = 16'd0;
        run(5);
        bus.duty_i = 16'd3;
        run(5);

        bus.period_i = 16'd8;
        bus.duty_i   = 16'd5;
        run(10);
        wait_k(2);
        bus.enable = 1'b0;
        run(8);
        check("stop_busy", int'(bus.busy_o), 0);
        check("stop_pwm", int'(bus.pwm_o), 0);
        bus.enable = 1'b1;
        run(12);
        wait_k(2);
        bus.enable = 1'b0;
        run(2);
        bus.enable = 1'b1;
        run(12);
        check("resume_busy", int'(bus.busy_o), 1);

        wait_k(3);
        #2;
        async_reset();
        run(15);

        bus.enable = 1'b0;
        #1;
        async_reset();
        bus.period_i = 16'd2;
        bus.duty_i   = 16'd1;
        bus.enable   = 1'b1;
        run(35);
        check("wrap_fc", int'(bus.frame_cnt_o), 1);

        for (int i = 0; i < 4000; i++) begin
            int sel;
            if ($urandom_range(0, 99) < 4) bus.enable = ~bus.enable;
            if ($urandom_range(0, 99) < 10) bus.period_i = W'($urandom_range(0, 12));
            if ($urandom_range(0, 99) < 20) begin
                sel = $urandom_range(0, 3);
                case (sel)
                    0: bus.duty_i = '0;
                    1: bus.duty_i = bus.period_i;
                    2: bus.duty_i = W'($urandom_range(0, 15));
                    default: bus.duty_i = W'($urandom_range(0, 65535));
                endcase
            end
            if ($urandom_range(0, 999) < 3) async_reset();
            tick();
        end

        bus.enable = 1'b0;
        run(3);
        @(negedge clk);
        #1;
        check("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
